uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver: 8N1-style frames (1 start, WORD_SIZE data LSB-first, 1 stop).
//  Receive-side counterpart of uart_transmitter; one instance sits in top on the uart_rx pin.
//  Uses a 16x oversampling tick, a 2-FF input synchroniser, and a one-deep holding register
//  with a read handshake plus sticky framing and overrun flags.
// PARAMETERS
//  DVSR       11  clk cycles per oversample tick (16 ticks = 1 bit; 40MHz/(11*16) ~ 230400 baud)
//  WORD_SIZE   8  data bits per frame
// PORTS
//  clk        in   1          system clock (clk40M in top)
//  nRST       in   1          asynchronous active-low reset
//  serialIn   in   1          UART line, idle high, asynchronous to clk
//  readByte   in   1          consumer pulse: dataOut taken, clears dataValid
//  clrErr     in   1          pulse: clears frameErr and overrun
//  dataOut    out  WORD_SIZE  last good received word
//  dataValid  out  1          level: dataOut holds an unread word
//  byteDone   out  1          1-cycle pulse when a good word is loaded into dataOut
//  frameErr   out  1          sticky: stop bit sampled 0
//  overrun    out  1          sticky: good word completed while dataValid=1 and readByte=0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser FFs 1; tick/bit counters and shift reg 0.
//  Sync: rxS = serialIn through 2 FFs (2-cycle latency). All decisions use rxS only.
//  Tick: divider counts 0..DVSR-1 and pulses tick at DVSR-1; cleared to 0 on entering START.
//  Sample counter sCnt (4b) counts ticks; bit counter nCnt counts 0..WORD_SIZE-1.
//  FSM:
//   IDLE : rxS==0 -> START (sCnt=0, divider=0).
//   START: on tick with sCnt==7 (mid start bit): rxS==0 -> DATA, sCnt=0, nCnt=0;
//          rxS==1 -> IDLE (glitch rejected, nothing reported).
//   DATA : on tick with sCnt==15: shift rxS into MSB of shift reg (right shift, LSB-first),
//          sCnt=0; if nCnt==WORD_SIZE-1 -> STOP else nCnt++.
//   STOP : on tick with sCnt==15: rxS==1 -> good frame, -> IDLE; rxS==0 -> frameErr=1, -> BREAK.
//   BREAK: wait for rxS==1 -> IDLE (line held low never retriggers a frame).
//  Good frame, clock after stop-bit sample:
//   dataValid==0 or readByte==1 -> dataOut=shift reg, dataValid=1, byteDone=1 for 1 cycle.
//   dataValid==1 and readByte==0 -> dataOut unchanged (old word kept), overrun=1, no byteDone.
//  readByte with dataValid=1 and no simultaneous completion -> dataValid=0 next clock.
//  readByte with dataValid=0 -> ignored.
//  Framing-error frame: data discarded; dataOut/dataValid untouched.
//  clrErr clears both flags next clock; if a new error occurs in the same cycle, set wins.
//  Reset mid-frame: immediate return to reset state; partial word lost; next full frame ok.
//  Latency: serialIn start edge -> dataValid ~ (WORD_SIZE+1.5)*16*DVSR + 3 clks.
// TESTING (DVSR=11, bit = 176 clks, bench drives serialIn directly)
//  1 frame 0xAB -> byteDone pulse once, dataOut=0xAB, dataValid=1, frameErr=0, overrun=0.
//  2 low glitch 44 clks then high -> no byteDone, FSM back to IDLE, next frame 0xA1 received ok.
//  3 frame 0x55 with stop=0, line then low 2000 clks -> frameErr=1, dataValid=0, no new frame
//    until line high; clrErr -> frameErr=0.
//  4 frames 0xA1 then 0xD0, no readByte -> dataOut=0xA1, overrun=1; clrErr -> overrun=0.
//  5 readByte in same clock as 0xD0 completion (0xA1 pending) -> dataOut=0xD0, dataValid=1,
//    overrun=0, byteDone=1.
//  6 nRST low during 4th data bit of 0xA0 -> all outputs 0; after release frame 0xD1 -> dataOut=0xD1.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled start/data/stop framing with a one-deep holding register,
// read handshake and sticky framing/overrun flags.
module uart_receiver #(
  parameter int DVSR      = 11,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 serialIn,
  input  logic                 readByte,
  input  logic                 clrErr,
  output logic [WORD_SIZE-1:0] dataOut,
  output logic                 dataValid,
  output logic                 byteDone,
  output logic                 frameErr,
  output logic                 overrun
);

  localparam int DW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_r;
  logic [1:0]           rxSync_r;
  logic [DW-1:0]        divCnt_r;
  logic [3:0]           sCnt_r;
  logic [NW-1:0]        nCnt_r;
  logic [WORD_SIZE-1:0] shiftReg_r;
  logic                 goodFrame_r;
  logic                 rxS_s;
  logic                 tick_s;

  assign rxS_s  = rxSync_r[1];
  assign tick_s = (divCnt_r == DW'(DVSR - 1));

  // Synchroniser, oversample divider, frame FSM and holding register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      rxSync_r    <= 2'b11;
      divCnt_r    <= {DW{1'b0}};
      sCnt_r      <= 4'd0;
      nCnt_r      <= {NW{1'b0}};
      shiftReg_r  <= {WORD_SIZE{1'b0}};
      goodFrame_r <= 1'b0;
      dataOut     <= {WORD_SIZE{1'b0}};
      dataValid   <= 1'b0;
      byteDone    <= 1'b0;
      frameErr    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rxSync_r    <= {rxSync_r[0], serialIn};
      divCnt_r    <= tick_s ? {DW{1'b0}} : divCnt_r + DW'(1);
      goodFrame_r <= 1'b0;
      byteDone    <= 1'b0;

      // Clears come first so a flag set later in this cycle takes priority.
      if (clrErr) begin
        frameErr <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        frameErr <= frameErr;
        overrun  <= overrun;
      end

      case (state_r)
        IDLE: begin
          if (!rxS_s) begin
            state_r  <= START;
            sCnt_r   <= 4'd0;
            divCnt_r <= {DW{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (tick_s) begin
            if (sCnt_r == 4'd7) begin
              sCnt_r  <= 4'd0;
              nCnt_r  <= {NW{1'b0}};
              state_r <= rxS_s ? IDLE : DATA;
            end else begin
              sCnt_r <= sCnt_r + 4'd1;
            end
          end else begin
            sCnt_r <= sCnt_r;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (sCnt_r == 4'd15) begin
              sCnt_r     <= 4'd0;
              shiftReg_r <= {rxS_s, shiftReg_r[WORD_SIZE-1:1]};
              if (nCnt_r == NW'(WORD_SIZE - 1)) begin
                state_r <= STOP;
              end else begin
                nCnt_r <= nCnt_r + NW'(1);
              end
            end else begin
              sCnt_r <= sCnt_r + 4'd1;
            end
          end else begin
            sCnt_r <= sCnt_r;
          end
        end
        STOP: begin
          if (tick_s) begin
            if (sCnt_r == 4'd15) begin
              sCnt_r <= 4'd0;
              if (rxS_s) begin
                goodFrame_r <= 1'b1;
                state_r     <= IDLE;
              end else begin
                frameErr <= 1'b1;
                state_r  <= BREAK;
              end
            end else begin
              sCnt_r <= sCnt_r + 4'd1;
            end
          end else begin
            sCnt_r <= sCnt_r;
          end
        end
        BREAK: begin
          // A line held low must return high before another start bit is accepted.
          state_r <= rxS_s ? IDLE : BREAK;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (goodFrame_r) begin
        if (!dataValid || readByte) begin
          dataOut   <= shiftReg_r;
          dataValid <= 1'b1;
          byteDone  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (readByte && dataValid) begin
        dataValid <= 1'b0;
      end else begin
        dataValid <= dataValid;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit-serially, expected words queued
// at stimulus time and popped on every byteDone pulse.
module tb_uart_receiver;

  localparam int BIT = 176;

  logic       clk40M;
  logic       nRST;
  logic       serialIn;
  logic       readByte;
  logic       clrErr;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       byteDone;
  logic       frameErr;
  logic       overrun;

  int         vectors;
  int         miscompares;
  logic [7:0] sb[$];

  uart_receiver #(.DVSR(11), .WORD_SIZE(8)) dut (
    .clk       (clk40M),
    .nRST      (nRST),
    .serialIn  (serialIn),
    .readByte  (readByte),
    .clrErr    (clrErr),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .byteDone  (byteDone),
    .frameErr  (frameErr),
    .overrun   (overrun)
  );

  initial clk40M = 1'b0;
  always #5 clk40M = ~clk40M;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    @(negedge clk40M);
    serialIn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk40M);
      serialIn = d[i];
    end
    repeat (BIT) @(negedge clk40M);
    serialIn = stopBit;
    repeat (BIT) @(negedge clk40M);
  endtask

  task automatic pulseRead();
    @(negedge clk40M);
    readByte = 1'b1;
    @(negedge clk40M);
    readByte = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk40M);
    clrErr = 1'b1;
    @(negedge clk40M);
    clrErr = 1'b0;
  endtask

  // Every byteDone must match the oldest queued word; an empty queue can never match.
  always @(negedge clk40M) begin
    if (nRST && byteDone) begin
      logic [31:0] expWord;
      expWord = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
      checkVal("byteDone.dataOut", 32'(dataOut), expWord);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b0;
    serialIn    = 1'b1;
    readByte    = 1'b0;
    clrErr      = 1'b0;
    repeat (5) @(negedge clk40M);
    checkVal("rst.dataOut", 32'(dataOut), 32'h0);
    checkVal("rst.flags", 32'({dataValid, byteDone, frameErr, overrun}), 32'h0);
    nRST = 1'b1;
    repeat (20) @(negedge clk40M);

    // 1: clean frame
    sb.push_back(8'hAB);
    sendFrame(8'hAB, 1'b1);
    repeat (10) @(negedge clk40M);
    checkVal("t1.dataOut", 32'(dataOut), 32'hAB);
    checkVal("t1.dataValid", 32'(dataValid), 32'h1);
    checkVal("t1.errs", 32'({frameErr, overrun}), 32'h0);
    pulseRead();
    checkVal("t1.readClears", 32'(dataValid), 32'h0);
    pulseRead();
    checkVal("t1.readIdle", 32'(dataValid), 32'h0);

    // 2: short low glitch is rejected, next frame still received
    @(negedge clk40M);
    serialIn = 1'b0;
    repeat (44) @(negedge clk40M);
    serialIn = 1'b1;
    repeat (300) @(negedge clk40M);
    checkVal("t2.glitchValid", 32'(dataValid), 32'h0);
    sb.push_back(8'hA1);
    sendFrame(8'hA1, 1'b1);
    repeat (10) @(negedge clk40M);
    checkVal("t2.dataOut", 32'(dataOut), 32'hA1);
    checkVal("t2.dataValid", 32'(dataValid), 32'h1);
    pulseRead();

    // 3: framing error followed by a long break
    sendFrame(8'h55, 1'b0);
    repeat (2000) @(negedge clk40M);
    checkVal("t3.frameErr", 32'(frameErr), 32'h1);
    checkVal("t3.dataValid", 32'(dataValid), 32'h0);
    serialIn = 1'b1;
    repeat (400) @(negedge clk40M);
    checkVal("t3.sticky", 32'(frameErr), 32'h1);
    checkVal("t3.noFrame", 32'(dataValid), 32'h0);
    pulseClr();
    checkVal("t3.clr", 32'(frameErr), 32'h0);

    // 4: overrun keeps the older word
    sb.push_back(8'hA1);
    sendFrame(8'hA1, 1'b1);
    sendFrame(8'hD0, 1'b1);
    repeat (10) @(negedge clk40M);
    checkVal("t4.dataOut", 32'(dataOut), 32'hA1);
    checkVal("t4.overrun", 32'(overrun), 32'h1);
    checkVal("t4.dataValid", 32'(dataValid), 32'h1);
    pulseClr();
    checkVal("t4.clr", 32'(overrun), 32'h0);

    // 5: read lands on the completion clock of 0xD0 while 0xA1 is pending
    sb.push_back(8'hD0);
    fork
      sendFrame(8'hD0, 1'b1);
      begin
        repeat (1676) @(negedge clk40M);
        readByte = 1'b1;
        @(negedge clk40M);
        readByte = 1'b0;
        checkVal("t5.byteDone", 32'(byteDone), 32'h1);
        checkVal("t5.dataOut", 32'(dataOut), 32'hD0);
        checkVal("t5.dataValid", 32'(dataValid), 32'h1);
        checkVal("t5.overrun", 32'(overrun), 32'h0);
      end
    join
    pulseRead();
    checkVal("t5.readClears", 32'(dataValid), 32'h0);

    // 6: reset in the middle of a frame, then a clean frame
    fork
      sendFrame(8'hA0, 1'b1);
      begin
        repeat (BIT * 4 + 88) @(negedge clk40M);
        nRST = 1'b0;
        @(negedge clk40M);
        checkVal("t6.rstDataOut", 32'(dataOut), 32'h0);
        checkVal("t6.rstFlags", 32'({dataValid, byteDone, frameErr, overrun}), 32'h0);
      end
    join
    repeat (5) @(negedge clk40M);
    nRST = 1'b1;
    repeat (50) @(negedge clk40M);
    sb.push_back(8'hD1);
    sendFrame(8'hD1, 1'b1);
    repeat (10) @(negedge clk40M);
    checkVal("t6.dataOut", 32'(dataOut), 32'hD1);
    checkVal("t6.flags", 32'({dataValid, frameErr, overrun}), 32'h4);

    checkVal("sb.drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
